// File: rtl/mips_lsu.sv
// mips_lsu: load/store unit with a req/gnt/rvalid memory handshake, big-endian lane steering and LL/SC.
// Define MIPS_LSU_TIMEOUT_EN to enable the REQ/RESP watchdog (limit set by TIMEOUT).
module mips_lsu #(
   parameter int ADDR_W  = 32,
   parameter int REG_AW  = 5,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              op_valid_i,
   input  logic              op_read_i,
   input  logic              op_write_i,
   input  logic              op_byte_i,
   input  logic              op_half_i,
   input  logic              op_signext_i,
   input  logic              op_ll_i,
   input  logic              op_sc_i,
   input  logic [ADDR_W-1:0] op_addr_i,
   input  logic [31:0]       op_wdata_i,
   input  logic [REG_AW-1:0] op_rd_i,
   output logic              op_ready_o,
   output logic              stall_o,
   output logic              mem_req_o,
   output logic [3:0]        mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [31:0]       mem_rdata_i,
   output logic              wb_valid_o,
   output logic [REG_AW-1:0] wb_rd_o,
   output logic [31:0]       wb_data_o,
   output logic              addr_err_o,
   output logic              timeout_err_o
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

   state_e state_q, state_d;

   logic              read_q, write_q, byte_q, half_q, signext_q, ll_q, sc_q;
   logic [ADDR_W-1:0] addr_q;
   logic [REG_AW-1:0] rd_q;
   logic [3:0]        we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              link_valid_q;
   logic [ADDR_W-3:0] link_addr_q;
   logic              wb_valid_q, addr_err_q;
   logic [REG_AW-1:0] wb_rd_q;
   logic [31:0]       wb_data_q;

   logic        op_fire, misaligned, link_hit, same_word;
   logic        start_req, misalign_evt, sc_fail_evt, completed, aborted, wd_hit;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_data;

   assign op_fire    = op_valid_i & (op_read_i | op_write_i);
   assign misaligned = (op_half_i & op_addr_i[0]) |
                       (~op_byte_i & ~op_half_i & (op_addr_i[1:0] != 2'b00));
   assign link_hit   = link_valid_q && (link_addr_q == op_addr_i[ADDR_W-1:2]);
   assign same_word  = (link_addr_q == addr_q[ADDR_W-1:2]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else if (en_i) begin
         state_q <= state_d;
      end
   end

   // A response or grant always takes priority over a watchdog expiry in the same cycle.
   always_comb begin
      state_d      = state_q;
      start_req    = 1'b0;
      misalign_evt = 1'b0;
      sc_fail_evt  = 1'b0;
      completed    = 1'b0;
      aborted      = 1'b0;
      if (en_i) begin
         unique case (state_q)
            IDLE: begin
               if (op_fire) begin
                  if (misaligned) begin
                     misalign_evt = 1'b1;
                  end else if (op_sc_i && !link_hit) begin
                     sc_fail_evt = 1'b1;
                  end else begin
                     start_req = 1'b1;
                     state_d   = REQ;
                  end
               end
            end
            REQ: begin
               if (mem_gnt_i) begin
                  state_d = RESP;
               end else if (wd_hit) begin
                  aborted = 1'b1;
                  state_d = IDLE;
               end
            end
            RESP: begin
               if (mem_rvalid_i) begin
                  completed = 1'b1;
                  state_d   = IDLE;
               end else if (wd_hit) begin
                  aborted = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      op_ready_o = (state_q == IDLE);
      mem_req_o  = (state_q == REQ);
      mem_we_o   = (state_q == REQ && write_q) ? we_q : 4'b0000;
      stall_o    = (state_q != IDLE) && !completed && !aborted;
   end

   assign mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata_o = wdata_q;

   // Lane 3 of the enable vector is byte offset 0 (big-endian).
   always_comb begin
      we_d    = 4'b1111;
      wdata_d = op_wdata_i;
      if (op_byte_i) begin
         we_d    = 4'b1000 >> op_addr_i[1:0];
         wdata_d = {4{op_wdata_i[7:0]}};
      end else if (op_half_i) begin
         we_d    = op_addr_i[1] ? 4'b0011 : 4'b1100;
         wdata_d = {2{op_wdata_i[15:0]}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         byte_q    <= 1'b0;
         half_q    <= 1'b0;
         signext_q <= 1'b0;
         ll_q      <= 1'b0;
         sc_q      <= 1'b0;
         addr_q    <= '0;
         rd_q      <= '0;
         we_q      <= 4'b0000;
         wdata_q   <= 32'd0;
      end else if (start_req) begin
         read_q    <= op_read_i;
         write_q   <= op_write_i;
         byte_q    <= op_byte_i;
         half_q    <= op_half_i;
         signext_q <= op_signext_i;
         ll_q      <= op_ll_i;
         sc_q      <= op_sc_i;
         addr_q    <= op_addr_i;
         rd_q      <= op_rd_i;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
      end
   end

   always_comb begin
      unique case (addr_q[1:0])
         2'd0:    lane_byte = mem_rdata_i[31:24];
         2'd1:    lane_byte = mem_rdata_i[23:16];
         2'd2:    lane_byte = mem_rdata_i[15:8];
         default: lane_byte = mem_rdata_i[7:0];
      endcase
      lane_half = addr_q[1] ? mem_rdata_i[15:0] : mem_rdata_i[31:16];
      if (byte_q) begin
         load_data = {{24{signext_q & lane_byte[7]}}, lane_byte};
      end else if (half_q) begin
         load_data = {{16{signext_q & lane_half[15]}}, lane_half};
      end else begin
         load_data = mem_rdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= 32'd0;
         addr_err_q <= 1'b0;
      end else if (en_i) begin
         wb_valid_q <= 1'b0;
         addr_err_q <= misalign_evt;
         if (sc_fail_evt) begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= op_rd_i;
            wb_data_q  <= 32'd0;
         end
         if (completed && (read_q || sc_q)) begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            wb_data_q  <= read_q ? load_data : 32'd1;
         end
         if (aborted && read_q) begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            wb_data_q  <= 32'hDEAD_BEEF;
         end
      end
   end

   // The clear is written last so a same-word store always beats a link set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         link_valid_q <= 1'b0;
         link_addr_q  <= '0;
      end else if (en_i && completed) begin
         if (read_q && ll_q) begin
            link_valid_q <= 1'b1;
            link_addr_q  <= addr_q[ADDR_W-1:2];
         end
         if (write_q && (sc_q || same_word)) begin
            link_valid_q <= 1'b0;
         end
      end
   end

   assign wb_valid_o = wb_valid_q;
   assign wb_rd_o    = wb_rd_q;
   assign wb_data_o  = wb_data_q;
   assign addr_err_o = addr_err_q;

`ifdef MIPS_LSU_TIMEOUT_EN
   logic [15:0] wd_cnt_q;
   logic        timeout_err_q;

   assign wd_hit = (wd_cnt_q == 16'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q      <= 16'd0;
         timeout_err_q <= 1'b0;
      end else if (en_i) begin
         timeout_err_q <= aborted;
         if (state_q == IDLE || state_d != state_q) begin
            wd_cnt_q <= 16'd0;
         end else begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
         end
      end
   end

   assign timeout_err_o = timeout_err_q;
`else
   assign wd_hit        = 1'b0;
   assign timeout_err_o = 1'b0;
`endif

endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
- Parametrised load/store unit for the 5-stage MIPS pipeline.
- Replaces the fixed single-cycle memory path between X and W with a request/grant/response handshake, so variable-latency memory (cache, bus bridge) can be used.
- Performs byte/half lane steering with big-endian lanes (byte offset 0 = bits [31:24]), sign/zero extension, misalignment detection and an LL/SC link reservation.
- Drives a pipeline stall while an access is in flight.

Parameters:
- ADDR_W, 32, address width; addr[1:0] is the byte offset.
- REG_AW, 5, destination register address width.
- TIMEOUT, 255, watchdog limit in cycles; used only with MIPS_LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; when low, all state and outputs hold.
- op_valid  in  1  X stage presents a memory op this cycle.
- op_read  in  1  load (LW/LH/LHU/LB/LBU/LL).
- op_write  in  1  store (SW/SH/SB/SC).
- op_byte  in  1  byte access.
- op_half  in  1  halfword access.
- op_signext  in  1  sign-extend load result.
- op_ll  in  1  load-linked.
- op_sc  in  1  store-conditional.
- op_addr  in  ADDR_W  effective address.
- op_wdata  in  32  store data, right-justified.
- op_rd  in  REG_AW  destination register.
- op_ready  out  1  op accepted this cycle.
- stall  out  1  freeze IF/ID/X.
- mem_req  out  1  memory request valid.
- mem_we  out  4  byte write enables; [3] = offset 0.
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits zero).
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  memory accepts the request.
- mem_rvalid  in  1  response valid (both loads and stores).
- mem_rdata  in  32  load data.
- wb_valid  out  1  write result to the register file.
- wb_rd  out  REG_AW  result register.
- wb_data  out  32  result data.
- addr_err  out  1  one-cycle pulse on misaligned access.
- timeout_err  out  1  one-cycle watchdog pulse (feature only).

Behaviour:
- Reset: state=IDLE, link_valid=0, link_addr=0. All outputs are 0 except op_ready=1.
- States:
  - IDLE: op_ready=1, stall=0.
    - op_valid & (op_read|op_write), aligned: latch op fields and go to REQ.
    - SC with link_valid=0 or word-address mismatch: no memory access; wb_valid=1, wb_data=0 next cycle; stay in IDLE.
    - Misaligned: no access; addr_err pulses next cycle; stay in IDLE.
  - REQ: mem_req=1, stall=1. On mem_gnt go to RESP. Address, data and enables stay stable until granted.
  - RESP: mem_req=0, stall=1. On mem_rvalid go to IDLE with stall=0 in that same cycle (zero-bubble release).
    - A second op may be accepted only in the cycle after return to IDLE.
    - mem_gnt and mem_rvalid may not both be seen in REQ; an rvalid in REQ is ignored.
- Latency: load result appears on wb_* exactly 1 cycle after the mem_rvalid cycle. Minimum op-to-wb latency is 3 cycles (gnt at cycle 1, rvalid at cycle 2).
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Write enables:
  - word: 4'b1111.
  - half: addr[1]=0 gives 4'b1100, else 4'b0011.
  - byte: one-hot 4'b1000 >> addr[1:0].
- Write data: half replicated {2{d[15:0]}}; byte replicated {4{d[7:0]}}.
- Load extract: byte lane selected by addr[1:0] (big-endian); half lane by addr[1]. Extension uses op_signext.
- wb_valid:
  - loads: 1 for one cycle.
  - SC: 1, wb_data=1 when the store completed, 0 when it failed.
  - plain stores: 0.
- Link reservation:
  - LL completing sets link_valid=1 and link_addr=addr[ADDR_W-1:2].
  - Any completed store (SW/SH/SB/SC) to the same word clears link_valid.
  - A successful SC always clears link_valid.
  - If LL and a same-word store complete in the same cycle, the store wins: link cleared.
- en=0: FSM, link and outputs frozen; mem_req held if already asserted.
- Async reset mid-transaction: returns to IDLE and drops mem_req immediately. Any later mem_rvalid is ignored until a new request is issued.

Optional Feature:
- Macro MIPS_LSU_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter counts cycles in REQ or RESP and clears on every state change.
  - On reaching TIMEOUT: timeout_err pulses for 1 cycle, FSM goes to IDLE, stall=0, mem_req=0.
  - An aborted load gives wb_valid=1, wb_data=32'hDEAD_BEEF.
- Undefined: no counter; timeout_err tied 0; the unit waits forever.

Test Plan:
- LW 0x100, gnt after 2 cycles, rvalid after 3 with rdata 0x11223344 -> stall high for 5 cycles; wb_valid=1, wb_rd as issued, wb_data=0x11223344.
- LB addr 0x103, rdata 0x000000F0, signext=1 -> wb_data=0xFFFFFFF0. Same with LBU -> wb_data=0x000000F0.
- SH addr 0x102, wdata 0xABCD1234 -> mem_we=4'b0011, mem_wdata=0x12341234, mem_addr=0x100, wb_valid=0.
- LL 0x200 -> SC 0x200 -> wb_data=1. LL 0x200, SB 0x203, SC 0x200 -> SC makes no mem_req, wb_data=0.
- LW addr 0x102 -> addr_err pulses, mem_req stays 0, op_ready=1.
- Feature on with TIMEOUT=4, gnt never asserted -> timeout_err after 4 cycles, stall drops, wb_data=0xDEADBEEF.
